mire_writer: RTL

Wishbone classic write master that fills the SDRAM framebuffer with a grid test pattern (mire), one 32-bit word per pixel, row-major from `ADR_BASE`. It sits upstream of the VGA display controller: it produces the frame that the display's Wishbone read path fetches into its pixel FIFO. It shares the SDRAM port through the bus arbiter and inserts idle gaps between writes so the display reader is never starved.

---
 rtl/mire_writer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mire_writer.sv
// mire_writer: Wishbone classic write master that fills an SDRAM framebuffer
// with a grid test pattern (white grid lines on black), one 32-bit word per
// pixel, row-major from ADR_BASE, with GAP idle cycles after every write so a
// display reader sharing the SDRAM port is never starved.
//
// Ports:
//   wshb_clk, wshb_rst_n  clock, asynchronous active-low reset
//   start                 one-cycle frame request (ignored while busy)
//   loop                  sampled at frame end: 1 restart, 0 stop
//   busy                  high while a frame (or looping frames) is running
//   frame_done            one-cycle pulse after the last pixel is acknowledged
//   cyc, stb, we, sel,
//   cti, bte, adr, dat_ms Wishbone master outputs (write only, classic cycles)
//   ack                   Wishbone slave acknowledge
module mire_writer #(
  parameter int unsigned HDISP    = 800,
  parameter int unsigned VDISP    = 480,
  parameter int unsigned GRID     = 16,
  parameter int unsigned GAP      = 16,
  parameter logic [31:0] ADR_BASE = 32'h0000_0000
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst_n,
  input  logic        start,
  input  logic        loop,
  output logic        busy,
  output logic        frame_done,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [3:0]  sel,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  input  logic        ack
);

  localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam bit          HAS_GAP = (GAP != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic [GW-1:0] r_gap_cnt;
  logic [31:0]   r_adr;
  logic [31:0]   r_dat;
  logic          r_cyc;
  logic          r_busy;
  logic          r_frame_done;
  logic          w_last_x;
  logic          w_last;
  logic          w_load;
  logic          w_adv;
  logic          w_done;
  logic          w_gap_load;
  logic          w_white;

  assign w_last_x = (r_x == XW'(HDISP - 1));
  assign w_last   = w_last_x && (r_y == YW'(VDISP - 1));

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_done      = 1'b0;
    w_gap_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_REQ;
          w_load      = 1'b1;
        end
      end
      S_REQ: begin
        if (ack) begin
          if (w_last) begin
            w_done = 1'b1;
            if (loop) begin
              w_load      = 1'b1;
              w_gap_load  = HAS_GAP;
              w_state_nxt = HAS_GAP ? S_GAP : S_REQ;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_adv       = 1'b1;
            w_gap_load  = HAS_GAP;
            w_state_nxt = HAS_GAP ? S_GAP : S_REQ;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= GW'(1)) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pixel coordinate of the next write: origin, raster-advanced, or held
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_load) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
    end else if (w_adv) begin
      if (w_last_x) begin
        w_x_nxt = '0;
        w_y_nxt = r_y + YW'(1);
      end else begin
        w_x_nxt = r_x + XW'(1);
      end
    end
  end

  // GRID is a power of two, so the modulo reduces to a mask
  assign w_white = ((32'(w_x_nxt) & 32'(GRID - 1)) == 32'd0) ||
                   ((32'(w_y_nxt) & 32'(GRID - 1)) == 32'd0);

  // State register
  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Datapath and registered outputs; address advances incrementally
  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_gap_cnt    <= '0;
      r_adr        <= ADR_BASE;
      r_dat        <= '0;
      r_cyc        <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_cyc        <= (w_state_nxt == S_REQ);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= w_done;
      if (w_gap_load)             r_gap_cnt <= GW'(GAP);
      else if (r_state == S_GAP)  r_gap_cnt <= r_gap_cnt - GW'(1);
      if (w_load)                 r_adr <= ADR_BASE;
      else if (w_adv)             r_adr <= r_adr + 32'd4;
      if (w_load || w_adv)        r_dat <= w_white ? 32'h00FF_FFFF : 32'h0000_0000;
    end
  end

  assign cyc        = r_cyc;
  assign stb        = r_cyc;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign adr        = r_adr;
  assign dat_ms     = r_dat;
  assign we         = 1'b1;
  assign sel        = 4'b1111;
  assign cti        = 3'b000;
  assign bte        = 2'b00;

endmodule
